// File: rtl/mac_pkg.sv
// Shared constants and the saturating accumulate helper for the MAC family.
// Blocks narrower than SAT_MAX_W sign-extend into the helper and slice the result.
package mac_pkg;

  localparam int LANES_DEF  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int unsigned SAT_MAX_W = 64;

  typedef struct packed {
    logic signed [SAT_MAX_W-1:0] value;
    logic                        ovf;
  } sat_res_t;

  // a and b must already lie in the signed acc_w range; value is sign-extended from acc_w bits.
  function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                       input logic signed [SAT_MAX_W-1:0] b,
                                       input int unsigned                 acc_w,
                                       input logic                        saturate);
    logic signed [SAT_MAX_W:0]   one_w;
    logic signed [SAT_MAX_W:0]   top_bit;
    logic signed [SAT_MAX_W:0]   sum;
    logic signed [SAT_MAX_W:0]   max_v;
    logic signed [SAT_MAX_W:0]   min_v;
    logic signed [SAT_MAX_W-1:0] wrapped;
    int unsigned                 sh;
    sat_res_t                    res;
    one_w   = {{SAT_MAX_W{1'b0}}, 1'b1};
    top_bit = one_w <<< (acc_w - 1);
    max_v   = top_bit - one_w;
    min_v   = -top_bit;
    sum     = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
    sh      = SAT_MAX_W - acc_w;
    wrapped = sum[SAT_MAX_W-1:0] << sh;
    res.ovf = (sum > max_v) || (sum < min_v);
    if (res.ovf && saturate) begin
      res.value = sum[SAT_MAX_W] ? min_v[SAT_MAX_W-1:0] : max_v[SAT_MAX_W-1:0];
    end else begin
      res.value = wrapped >>> sh;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_add_tree.sv
// Combinational signed reduction of LANES packed operands; the result width
// grows by clog2(LANES) so the sum can never overflow.
module mac_add_tree #(
  parameter  int LANES = 4,
  parameter  int IN_W  = 16,
  localparam int OUT_W = IN_W + $clog2(LANES)
) (
  input  logic [LANES*IN_W-1:0] operands_i,
  output logic signed [OUT_W-1:0] sum_o
);

  // Written as a chain; synthesis rebalances it into a tree.
  always_comb begin
    // NOTE: assign a default before any loop or branch so no path leaves the output unassigned (no latch).
    sum_o = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_o = sum_o + OUT_W'(signed'(operands_i[i*IN_W +: IN_W]));
    end
  end

endmodule

// File: rtl/mac_vec.sv
// Two-stage vector multiply-accumulate: S1 registers lane products, S2 reduces
// them and accumulates until a last beat, then presents the result valid/ready.
module mac_vec import mac_pkg::*; #(
  parameter int LANES    = LANES_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_overflow
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  logic                          stall;
  logic                          accept;
  logic                          advance;
  logic [LANES*PROD_W-1:0]       prod_d;
  logic [LANES*PROD_W-1:0]       prod_q;
  logic                          s1_valid_q;
  logic                          s1_last_q;
  logic signed [SUM_W-1:0]       tree_sum;
  sat_res_t                      sum_res;
  logic                          unused_sat_bits;
  logic signed [ACC_W-1:0]       acc_q;
  logic                          ovf_q;
  logic [ACC_W-1:0]              out_data_q;
  logic                          out_ovf_q;
  logic                          out_valid_q;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !rst && !clear && !stall;
  assign accept   = in_valid && in_ready;
  // S2 consumes the S1 beat this cycle; a clear discards it instead.
  assign advance  = s1_valid_q && !stall && !clear;

  always_comb begin
    prod_d = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_d[i*PROD_W +: PROD_W] = PROD_W'(signed'(in_a[i*DATA_W +: DATA_W]))
                                 * PROD_W'(signed'(in_b[i*DATA_W +: DATA_W]));
    end
  end

  // NOTE: products and the last flag are qualified by s1_valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      prod_q    <= prod_d;
      s1_last_q <= in_last;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || clear) begin
      s1_valid_q <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= accept;
    end
  end

  mac_add_tree #(
    .LANES (LANES),
    .IN_W  (PROD_W)
  ) u_tree (
    .operands_i (prod_q),
    .sum_o      (tree_sum)
  );

  always_comb begin
    sum_res = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(tree_sum), ACC_W, SATURATE != 0);
  end

  assign unused_sat_bits = ^sum_res.value;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      if (s1_last_q) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        acc_q <= sum_res.value[ACC_W-1:0];
        ovf_q <= ovf_q | sum_res.ovf;
      end
    end
  end

  // Reloading on the same edge a result transfers keeps back-to-back results bubble-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (advance && s1_last_q) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sum_res.value[ACC_W-1:0];
      out_ovf_q   <= ovf_q | sum_res.ovf;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_mac_vec.sv
// Directed bench for mac_vec: a default instance plus two 20-bit accumulator
// instances (saturating and wrapping) sharing the same stimulus.
module tb_mac_vec;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_last;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_ready;

  logic               in_ready, out_valid, out_overflow;
  logic signed [31:0] out_data;
  logic               sat_in_ready, sat_valid, sat_ovf;
  logic signed [19:0] sat_data;
  logic               wrap_in_ready, wrap_valid, wrap_ovf;
  logic signed [19:0] wrap_data;

  int total = 0;
  int bad   = 0;
  logic signed [31:0] got_q[$];

  always #5 clk = ~clk;

  mac_vec dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_overflow(out_overflow)
  );

  mac_vec #(.ACC_W(20), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_last(in_last), .in_a(in_a), .in_b(in_b), .out_valid(sat_valid),
    .out_ready(out_ready), .out_data(sat_data), .out_overflow(sat_ovf)
  );

  mac_vec #(.ACC_W(20), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(wrap_in_ready),
    .in_last(in_last), .in_a(in_a), .in_b(in_b), .out_valid(wrap_valid),
    .out_ready(out_ready), .out_data(wrap_data), .out_overflow(wrap_ovf)
  );

  // Records every result that transfers at the following rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic last);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_last  = last;
  endtask

  function automatic logic [31:0] lanes4(input int v0, input int v1, input int v2, input int v3);
    return {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
  endfunction

  initial begin
    logic [31:0] ones, twos, threes, fours;
    ones   = lanes4(1, 1, 1, 1);
    twos   = lanes4(2, 2, 2, 2);
    threes = lanes4(3, 3, 3, 3);
    fours  = lanes4(4, 4, 4, 4);

    rst = 1'b1; clear = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", out_overflow, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 1);

    // Single beat: 1*5+2*6+3*7+4*8 = 70, valid two edges after acceptance.
    drive(1'b1, lanes4(1, 2, 3, 4), lanes4(5, 6, 7, 8), 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("single_not_yet", out_valid, 0);
    tick();
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 70);
    check("single_ovf", out_overflow, 0);
    tick();
    check("single_drop", out_valid, 0);

    // Three beats of 48 -> 144, then a single beat of 4*(5*-2) = -40 with no gap.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, threes, fours, i == 2);
      check("b2b_in_ready", in_ready, 1);
      tick();
    end
    drive(1'b1, lanes4(5, 5, 5, 5), lanes4(-2, -2, -2, -2), 1'b1);
    check("b2b_in_ready", in_ready, 1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("b2b_first_valid", out_valid, 1);
    check("b2b_first_data", out_data, 144);
    tick();
    check("b2b_second_valid", out_valid, 1);
    check("b2b_second_data", out_data, -40);
    tick();
    check("b2b_drop", out_valid, 0);

    // 8 beats of 65536 = 524288: over a 20-bit accumulator, fits in 32 bits.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, lanes4(-128, -128, -128, -128), lanes4(-128, -128, -128, -128), i == 7);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("sat_valid", sat_valid, 1);
    check("sat_data", sat_data, 524287);
    check("sat_ovf", sat_ovf, 1);
    check("wrap_data", wrap_data, -524288);
    check("wrap_ovf", wrap_ovf, 1);
    check("wide_data", out_data, 524288);
    check("wide_ovf", out_overflow, 0);
    tick();

    // Backpressure: results 8, 12, 16 offered while out_ready is held low.
    got_q.delete();
    out_ready = 1'b0;
    drive(1'b1, ones, twos, 1'b1);
    tick();
    drive(1'b1, ones, threes, 1'b1);
    check("stall_pre_ready", in_ready, 1);
    tick();
    check("stall_valid", out_valid, 1);
    drive(1'b1, ones, fours, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_data", out_data, 8);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("release_data1", out_data, 12);
    tick();
    check("release_data2", out_data, 16);
    tick();
    check("release_drop", out_valid, 0);
    check("release_count", got_q.size(), 3);
    check("release_q0", (got_q.size() > 0) ? got_q[0] : 32'sd0, 8);
    check("release_q1", (got_q.size() > 1) ? got_q[1] : 32'sd0, 12);
    check("release_q2", (got_q.size() > 2) ? got_q[2] : 32'sd0, 16);

    // Two beats of 12, a clear, then a last beat of 10 -> only 10 survives.
    drive(1'b1, ones, threes, 1'b0);
    tick();
    tick();
    clear = 1'b1;
    drive(1'b1, lanes4(1, 2, 3, 4), ones, 1'b1);
    #1;
    check("clear_in_ready", in_ready, 0);
    tick();
    clear = 1'b0;
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("clear_valid", out_valid, 1);
    check("clear_data", out_data, 10);
    check("clear_ovf", out_overflow, 0);
    tick();

    // Reset with a pending result and a partial beat still in the pipeline.
    drive(1'b1, ones, twos, 1'b1);
    tick();
    drive(1'b1, ones, threes, 1'b0);
    tick();
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    check("prerst_valid", out_valid, 1);
    check("prerst_data", out_data, 8);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_ovf", out_overflow, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_sat_data", sat_data, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, ones, ones, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("postrst_valid", out_valid, 1);
    check("postrst_data", out_data, 4);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
